// File: rtl/cronometro_pkg.sv
// Shared definitions for the stopwatch controller: FSM state type with its fixed
// encodings, default timing constants and a small state-classification helper.
package cronometro_pkg;

  // Encodings are visible on state_o, so they are pinned explicitly.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StLap   = 2'd3
  } state_e;

  localparam int unsigned CLK_HZ_DEFAULT     = 50_000_000;
  localparam int unsigned TICK_HZ_DEFAULT    = 100;
  localparam int unsigned DEB_CYCLES_DEFAULT = 1_000_000;

  // States in which time advances (the prescaler counts).
  function automatic logic is_counting(state_e s);
    return (s == StRun) || (s == StLap);
  endfunction

endpackage

// File: rtl/cronometro_ctrl_key_debounce.sv
// key_debounce: 2-FF synchronizer plus debouncer for one active-low pushbutton.
// Ports:
//   clk_i    system clock
//   rst_i    asynchronous active-high reset
//   key_n_i  raw active-low key, asynchronous to clk_i
//   press_o  one-cycle pulse on each accepted press
module key_debounce
  import cronometro_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic press_o
);

  localparam int unsigned CntW = $clog2(DEB_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            press_q, press_d;

  // The debounced level comes out of reset as "pressed" (0): a key held
  // through reset must first be seen released before a press can register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  // cnt_q counts consecutive samples that disagree with the debounced level;
  // any agreeing sample restarts the window.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntMax) begin
        level_d = sync2_q;
        press_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/cronometro_ctrl.sv
// cronometro_ctrl: stopwatch control FSM (IDLE/RUN/PAUSE/LAP) with a tick
// prescaler and two debounced pushbuttons.
// Ports:
//   CLOCK_50   system clock
//   reset      asynchronous active-high reset
//   key_ss_n   start/stop key, active-low, asynchronous
//   key_lr_n   lap/reset key, active-low, asynchronous
//   cnt_en     one-cycle pulse: counter datapath advances one step
//   cnt_clr    one-cycle pulse: counter datapath clears
//   disp_hold  level: display frozen (LAP)
//   state_o    current state encoding
module cronometro_ctrl
  import cronometro_pkg::*;
#(
  parameter int unsigned CLK_HZ     = CLK_HZ_DEFAULT,
  parameter int unsigned TICK_HZ    = TICK_HZ_DEFAULT,
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       key_ss_n,
  input  logic       key_lr_n,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       disp_hold,
  output logic [1:0] state_o
);

  localparam int unsigned DIV    = CLK_HZ / TICK_HZ;
  localparam int unsigned PrescW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PrescW-1:0] PrescMax = PrescW'(DIV - 1);

  logic ss_ev, lr_ev;

  key_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb_ss (
    .clk_i  (CLOCK_50),
    .rst_i  (reset),
    .key_n_i(key_ss_n),
    .press_o(ss_ev)
  );

  key_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb_lr (
    .clk_i  (CLOCK_50),
    .rst_i  (reset),
    .key_n_i(key_lr_n),
    .press_o(lr_ev)
  );

  state_e            state_q, state_d;
  logic [PrescW-1:0] presc_q, presc_d;
  logic              cnt_en_q, cnt_en_d;
  logic              cnt_clr_q, cnt_clr_d;
  logic              disp_hold_q, disp_hold_d;
  logic              clr_take;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      presc_q     <= '0;
      cnt_en_q    <= 1'b0;
      cnt_clr_q   <= 1'b0;
      disp_hold_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      cnt_en_q    <= cnt_en_d;
      cnt_clr_q   <= cnt_clr_d;
      disp_hold_q <= disp_hold_d;
    end
  end

  // Next state. ss has priority; an lr arriving with ss is dropped.
  always_comb begin
    state_d  = state_q;
    clr_take = 1'b0;
    if (ss_ev) begin
      case (state_q)
        StIdle:  state_d = StRun;
        StRun:   state_d = StPause;
        StPause: state_d = StRun;
        StLap:   state_d = StPause;
        default: state_d = StIdle;
      endcase
    end else if (lr_ev) begin
      case (state_q)
        StRun:   state_d = StLap;
        StLap:   state_d = StRun;
        StPause: begin
          state_d  = StIdle;
          clr_take = 1'b1;
        end
        StIdle:  clr_take = 1'b1;
        default: state_d = StIdle;
      endcase
    end
  end

  // Prescaler and registered outputs. The wrap is judged on the current
  // state, so the first tick lands DIV cycles after entering RUN.
  always_comb begin
    presc_d  = presc_q;
    cnt_en_d = 1'b0;
    if (is_counting(state_q)) begin
      if (presc_q == PrescMax) begin
        presc_d  = '0;
        cnt_en_d = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end else if (state_q == StIdle) begin
      presc_d = '0;
    end
    if (clr_take) begin
      presc_d = '0;
    end
    cnt_clr_d   = clr_take;
    disp_hold_d = (state_d == StLap);
  end

  assign cnt_en    = cnt_en_q;
  assign cnt_clr   = cnt_clr_q;
  assign disp_hold = disp_hold_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_cronometro_ctrl.sv
// Scoreboard bench for cronometro_ctrl (DIV=10, DEB_CYCLES=4). A reference
// model pushes the expected output set after every clock edge; a monitor pops
// and compares on the falling edge.
module tb_cronometro_ctrl;

  localparam int unsigned CLK_HZ  = 1000;
  localparam int unsigned TICK_HZ = 100;
  localparam int unsigned DEB     = 4;
  localparam int unsigned DIV     = CLK_HZ / TICK_HZ;

  localparam logic [1:0] M_IDLE  = 2'd0;
  localparam logic [1:0] M_RUN   = 2'd1;
  localparam logic [1:0] M_PAUSE = 2'd2;
  localparam logic [1:0] M_LAP   = 2'd3;

  typedef struct packed {
    logic [1:0] st;
    logic       en;
    logic       clr;
    logic       hold;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_ss_n = 1'b1;
  logic       key_lr_n = 1'b1;
  logic       cnt_en, cnt_clr, disp_hold;
  logic [1:0] state_o;

  int vectors = 0;
  int miscompares = 0;

  rec_t exp_q[$];

  cronometro_ctrl #(
    .CLK_HZ    (CLK_HZ),
    .TICK_HZ   (TICK_HZ),
    .DEB_CYCLES(DEB)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .key_ss_n (key_ss_n),
    .key_lr_n (key_lr_n),
    .cnt_en   (cnt_en),
    .cnt_clr  (cnt_clr),
    .disp_hold(disp_hold),
    .state_o  (state_o)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Keys pass a 2-sample delay (synchronizer, reset high). A key counts as
  // released after DEB consecutive high samples; a press is DEB consecutive
  // low samples after a release. The FSM acts on a press one edge later.
  logic [1:0] m_state;
  int         active_cycles;
  logic       sd1 [2];
  logic       sd2 [2];
  int         low_run [2];
  int         high_run [2];
  bit         released [2];
  bit         ev [2];

  task automatic model_reset();
    m_state       = M_IDLE;
    active_cycles = 0;
    for (int k = 0; k < 2; k++) begin
      sd1[k] = 1'b1; sd2[k] = 1'b1;
      low_run[k] = 0; high_run[k] = 0;
      released[k] = 1'b0; ev[k] = 1'b0;
    end
  endtask

  initial begin
    rec_t r;
    logic ss, lr, s;
    logic keys [2];
    model_reset();
    forever begin
      @(posedge clk);
      r = '0;
      if (rst) begin
        model_reset();
      end else begin
        ss = ev[0];
        lr = ev[1];
        if (m_state == M_RUN || m_state == M_LAP) begin
          active_cycles++;
          if (active_cycles % DIV == 0) r.en = 1'b1;
        end
        if (ss) begin
          case (m_state)
            M_IDLE:  m_state = M_RUN;
            M_RUN:   m_state = M_PAUSE;
            M_PAUSE: m_state = M_RUN;
            default: m_state = M_PAUSE;
          endcase
        end else if (lr) begin
          case (m_state)
            M_RUN:   m_state = M_LAP;
            M_LAP:   m_state = M_RUN;
            default: begin
              m_state       = M_IDLE;
              r.clr         = 1'b1;
              active_cycles = 0;
            end
          endcase
        end
        r.st   = m_state;
        r.hold = (m_state == M_LAP);
        keys[0] = key_ss_n;
        keys[1] = key_lr_n;
        for (int k = 0; k < 2; k++) begin
          s = sd2[k];
          sd2[k] = sd1[k];
          sd1[k] = keys[k];
          if (s) begin high_run[k]++; low_run[k] = 0; end
          else begin low_run[k]++; high_run[k] = 0; end
          ev[k] = 1'b0;
          if (high_run[k] == DEB) released[k] = 1'b1;
          if (low_run[k] == DEB && released[k]) begin
            ev[k] = 1'b1;
            released[k] = 1'b0;
          end
        end
      end
      exp_q.push_back(r);
    end
  end

  // ---------------- monitor ----------------
  initial begin
    rec_t e, g;
    forever begin
      @(negedge clk);
      vectors++;
      g = '{st: state_o, en: cnt_en, clr: cnt_clr, hold: disp_hold};
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_empty t=%0t got st=%0d en=%0b clr=%0b hold=%0b",
                 $time, g.st, g.en, g.clr, g.hold);
      end else begin
        e = exp_q.pop_front();
        if (g !== e) begin
          miscompares++;
          $display("FAIL outputs t=%0t got st=%0d en=%0b clr=%0b hold=%0b exp st=%0d en=%0b clr=%0b hold=%0b",
                   $time, g.st, g.en, g.clr, g.hold, e.st, e.en, e.clr, e.hold);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // All drives happen 1 time unit after a falling edge.
  task automatic hold_keys(input logic ss_n, input logic lr_n, input int n);
    key_ss_n = ss_n;
    key_lr_n = lr_n;
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic press_ss();
    hold_keys(1'b0, 1'b1, 10);
    hold_keys(1'b1, 1'b1, 10);
  endtask

  task automatic press_lr();
    hold_keys(1'b1, 1'b0, 10);
    hold_keys(1'b1, 1'b1, 10);
  endtask

  task automatic press_both();
    hold_keys(1'b0, 1'b0, 10);
    hold_keys(1'b1, 1'b1, 10);
  endtask

  task automatic bounce_ss();
    for (int i = 0; i < 4; i++) begin
      hold_keys(1'b0, 1'b1, 3);
      hold_keys(1'b1, 1'b1, 2);
    end
    hold_keys(1'b1, 1'b1, 10);
  endtask

  task automatic check_async_zero(input string name);
    logic [4:0] got;
    got = {state_o, cnt_en, cnt_clr, disp_hold};
    vectors++;
    if (got !== 5'b0) begin
      miscompares++;
      $display("FAIL %s got st=%0d en=%0b clr=%0b hold=%0b exp all zero",
               name, state_o, cnt_en, cnt_clr, disp_hold);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int sel, lo, hi;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    hold_keys(1'b1, 1'b1, 20);

    // start, run through several ticks
    press_ss();
    hold_keys(1'b1, 1'b1, 25);
    // bounce only: no effect
    bounce_ss();
    // pause mid-period, stay paused, resume
    press_ss();
    hold_keys(1'b1, 1'b1, 50);
    press_ss();
    hold_keys(1'b1, 1'b1, 15);
    // lap and back
    press_lr();
    hold_keys(1'b1, 1'b1, 30);
    press_lr();
    // pause then clear
    press_ss();
    press_lr();
    // clear while idle
    press_lr();
    // simultaneous keys in RUN -> PAUSE
    press_ss();
    press_both();
    // simultaneous keys in PAUSE -> RUN, no clear
    press_both();

    // asynchronous reset during LAP
    press_lr();
    hold_keys(1'b1, 1'b1, 17);
    rst = 1'b1;
    #1;
    check_async_zero("async_reset_in_lap");
    @(negedge clk);
    #1;
    rst = 1'b0;
    hold_keys(1'b1, 1'b1, 20);

    // key held low through reset: no event until released and pressed again
    key_ss_n = 1'b0;
    do_reset();
    hold_keys(1'b0, 1'b1, 30);
    hold_keys(1'b1, 1'b1, 10);
    press_ss();

    // randomized phase
    for (int i = 0; i < 250; i++) begin
      sel = $urandom_range(0, 9);
      lo  = $urandom_range(1, 8);
      hi  = $urandom_range(1, 12);
      case (sel)
        0, 1, 2: begin hold_keys(1'b0, 1'b1, lo); hold_keys(1'b1, 1'b1, hi); end
        3, 4, 5: begin hold_keys(1'b1, 1'b0, lo); hold_keys(1'b1, 1'b1, hi); end
        6:       begin hold_keys(1'b0, 1'b0, lo); hold_keys(1'b1, 1'b1, hi); end
        7:       hold_keys(1'b1, 1'b1, $urandom_range(1, 40));
        8:       bounce_ss();
        default: begin
          if ($urandom_range(0, 3) == 0) begin
            rst = 1'b1;
            #1;
            check_async_zero("async_reset_random");
            @(negedge clk);
            #1;
            rst = 1'b0;
          end
          hold_keys(1'b1, 1'b1, hi);
        end
      endcase
    end
    hold_keys(1'b1, 1'b1, 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard bound on total simulated time.
  initial begin
    #2_000_000;
    $display("FAIL timeout vectors=%0d exp finish before time limit", vectors);
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1);
  end

endmodule

// File: doc/cronometro_ctrl.md
CRONOMETRO_CTRL -- requirements
Module: cronometro_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 100, count-enable rate in Hz; DIV = CLK_HZ/TICK_HZ.
REQ-003 SHALL have parameter DEB_CYCLES, default 1_000_000, debounce stability window in clocks (20 ms).
REQ-004 SHALL have one clock and an asynchronous, active-high reset: CLOCK_50  input  1  system clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 key_ss_n  input  1  start/stop pushbutton, active-low, asynchronous to CLOCK_50.
REQ-007 key_lr_n  input  1  lap/reset pushbutton, active-low, asynchronous to CLOCK_50.
REQ-008 cnt_en  output  1  one-cycle pulse; the counter datapath advances one step.
REQ-009 cnt_clr  output  1  one-cycle pulse; the counter datapath clears to zero.
REQ-010 disp_hold  output  1  level; the display latches and freezes its current value.
REQ-011 state_o  output  2  current FSM state encoding (IDLE=0, RUN=1, PAUSE=2, LAP=3).

Function
REQ-012 Each key SHALL pass through a 2-FF synchronizer and a debouncer; a press event is a 1-cycle pulse when the synchronized level has been stable low for DEB_CYCLES consecutive clocks after being stable high.
REQ-013 Bounces shorter than DEB_CYCLES SHALL produce no event; a held key SHALL produce exactly one event until it is released and re-pressed.
REQ-014 The FSM SHALL have states IDLE, RUN, PAUSE, and LAP; ss and lr denote debounced press events.
REQ-015 Transitions SHALL be: IDLE+ss->RUN; RUN+ss->PAUSE; PAUSE+ss->RUN; RUN+lr->LAP; LAP+lr->RUN; LAP+ss->PAUSE; PAUSE+lr->IDLE; IDLE+lr->IDLE.
REQ-016 On the same cycle as ss and lr, ss SHALL win and lr SHALL be discarded.
REQ-017 cnt_clr SHALL pulse in the cycle following any lr event taken in PAUSE or IDLE, and never in other states.
REQ-018 The prescaler SHALL count 0..DIV-1, advance only in RUN and LAP, hold its value in PAUSE, and be forced to 0 in IDLE.
REQ-019 cnt_en SHALL pulse for one cycle when the prescaler wraps DIV-1->0 in RUN or LAP, so the first pulse occurs DIV cycles after leaving IDLE.
REQ-020 disp_hold SHALL be 1 exactly while in LAP, registered, and update in the same cycle as state_o.
REQ-021 cnt_en and cnt_clr SHALL never be asserted in the same cycle.
REQ-022 All outputs SHALL be registered, with a latency of 1 clock from the internal event to the output.

Reset
REQ-023 On reset assertion, asynchronously: state=IDLE, prescaler=0, debouncer counters=0, synchronizers=1 (released), cnt_en=0, cnt_clr=0, disp_hold=0, state_o=0.
REQ-024 A reset asserted mid-RUN or mid-LAP SHALL drop disp_hold and cnt_en immediately, and SHALL NOT generate a cnt_clr pulse.
REQ-025 After reset release, a key already held low SHALL produce no event until it is released and re-pressed.

Structure
REQ-026 Package cronometro_pkg SHALL hold the state enum typedef (2-bit), the state encodings, and the default CLK_HZ/TICK_HZ/DEB_CYCLES constants.
REQ-027 Synchronizer and debounce logic SHALL be one sub-module, key_debounce, instantiated twice with parameter DEB_CYCLES.
REQ-028 The prescaler width SHALL be $clog2(DIV) and the debounce counter width SHALL be $clog2(DEB_CYCLES+1).

Verification (CLK_HZ=1000, TICK_HZ=100 -> DIV=10, DEB_CYCLES=4)
REQ-029 Reset, then key_ss_n low for 10 clocks -> state_o 0->1 once; cnt_en first pulses 10 clocks after the transition, then every 10 clocks.
REQ-030 key_ss_n bounce of 3-clock lows separated by 2-clock highs -> no state change, cnt_en stays 0.
REQ-031 Run to prescaler=6, press ss, wait 50 clocks, press ss -> no cnt_en while paused; first pulse 4 clocks after returning to RUN.
REQ-032 RUN, press lr -> disp_hold=1, state_o=3, cnt_en continues every 10 clocks; press lr again -> disp_hold=0, state_o=1.
REQ-033 PAUSE, press lr -> exactly one cnt_clr pulse, state_o=0; ss and lr events on the same cycle in RUN -> state_o=2, no LAP.
REQ-034 Assert reset during LAP -> disp_hold, cnt_en, and state_o go to 0 without a clock edge; no cnt_clr pulse.
